// File: rtl/ex_mem_stage_reg_if.sv
// EX->MEM stage handshake bundle: EX-side offer, MEM-side head entry.
// slave = the stage register itself, master = the EX/MEM environment driving it.
interface ex_mem_stage_reg_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_pc;
   logic [DATA_W-1:0]     in_result;
   logic [DATA_W-1:0]     in_store_data;
   logic [REG_ADDR_W-1:0] in_dest_reg;
   logic                  in_reg_write;
   logic                  in_mem_read;
   logic                  in_mem_write;
   logic                  in_overflow;
   logic                  in_trap_ovf;
   logic                  in_op_invalid;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_pc;
   logic [DATA_W-1:0]     out_result;
   logic [DATA_W-1:0]     out_store_data;
   logic [REG_ADDR_W-1:0] out_dest_reg;
   logic                  out_reg_write;
   logic                  out_mem_read;
   logic                  out_mem_write;
   logic                  out_exc;
   logic [4:0]            out_exc_code;

   modport slave (
      input  in_valid, in_pc, in_result, in_store_data, in_dest_reg,
             in_reg_write, in_mem_read, in_mem_write,
             in_overflow, in_trap_ovf, in_op_invalid, out_ready,
      output in_ready, out_valid, out_pc, out_result, out_store_data,
             out_dest_reg, out_reg_write, out_mem_read, out_mem_write,
             out_exc, out_exc_code
   );

   modport master (
      output in_valid, in_pc, in_result, in_store_data, in_dest_reg,
             in_reg_write, in_mem_read, in_mem_write,
             in_overflow, in_trap_ovf, in_op_invalid, out_ready,
      input  in_ready, out_valid, out_pc, out_result, out_store_data,
             out_dest_reg, out_reg_write, out_mem_read, out_mem_write,
             out_exc, out_exc_code
   );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register as a 2-entry skid buffer with exception marking and squash.
// Optional trapping-overflow exception enabled by defining EX_MEM_OVF_TRAP_EN.
//
// state     | meaning
// ST_EMPTY  | no entry held, out_valid=0, in_ready=1
// ST_ONE    | head holds an entry, skid empty, in_ready=1
// ST_TWO    | head and skid both hold entries, in_ready=0
module ex_mem_stage_reg #(
   parameter int         DATA_W     = 32,
   parameter int         REG_ADDR_W = 5,
   parameter logic [4:0] EXC_RI     = 5'd10,
   parameter logic [4:0] EXC_OV     = 5'd12
) (
   input logic               clk,
   input logic               rst_n,
   input logic               flush,
   ex_mem_stage_reg_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     result;
      logic [DATA_W-1:0]     store_data;
      logic [REG_ADDR_W-1:0] dest_reg;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  exc;
      logic [4:0]            exc_code;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_q;
   entry_t head_q;
   entry_t skid_q;
   entry_t new_entry;
   logic   squash_q;
   logic   in_ready_q;
   logic   out_valid_q;

   logic   fault_ri;
   logic   fault_ov;
   logic   fault;
   logic   accept;
   logic   pop;
   logic   keep;

   assign fault_ri = bus.in_op_invalid;
`ifdef EX_MEM_OVF_TRAP_EN
   assign fault_ov = bus.in_overflow & bus.in_trap_ovf & ~bus.in_op_invalid;
`else
   logic unused_ovf;
   assign unused_ovf = bus.in_overflow ^ bus.in_trap_ovf;
   assign fault_ov   = 1'b0;
`endif
   assign fault = fault_ri | fault_ov;

   // Faulting entries keep pc/result/dest for the handler but lose all side effects.
   always_comb begin
      new_entry            = '0;
      new_entry.pc         = bus.in_pc;
      new_entry.result     = bus.in_result;
      new_entry.store_data = bus.in_store_data;
      new_entry.dest_reg   = bus.in_dest_reg;
      new_entry.reg_write  = bus.in_reg_write & ~fault;
      new_entry.mem_read   = bus.in_mem_read  & ~fault;
      new_entry.mem_write  = bus.in_mem_write & ~fault;
      new_entry.exc        = fault;
      if (fault_ri)
         new_entry.exc_code = EXC_RI;
      else if (fault_ov)
         new_entry.exc_code = EXC_OV;
      else
         new_entry.exc_code = 5'd0;
   end

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = out_valid_q & bus.out_ready;
   // While squashing, the handshake still completes but nothing is stored.
   assign keep   = accept & ~squash_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         squash_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         squash_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         if (keep && new_entry.exc)
            squash_q <= 1'b1;
         case (state_q)
            ST_EMPTY: begin
               if (keep) begin
                  head_q      <= new_entry;
                  state_q     <= ST_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (keep && pop) begin
                  head_q <= new_entry;
               end else if (keep) begin
                  skid_q     <= new_entry;
                  state_q    <= ST_TWO;
                  in_ready_q <= 1'b0;
               end else if (pop) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  head_q     <= skid_q;
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_pc         = head_q.pc;
   assign bus.out_result     = head_q.result;
   assign bus.out_store_data = head_q.store_data;
   assign bus.out_dest_reg   = head_q.dest_reg;
   assign bus.out_reg_write  = head_q.reg_write;
   assign bus.out_mem_read   = head_q.mem_read;
   assign bus.out_mem_write  = head_q.mem_write;
   assign bus.out_exc        = head_q.exc;
   assign bus.out_exc_code   = head_q.exc_code;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios plus random traffic
// compared against a queue-based reference model of the stage.
module tb_ex_mem_stage_reg;

   localparam int DW = 32;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   ex_mem_stage_reg_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus ();

   ex_mem_stage_reg #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] result;
      logic [DW-1:0] sd;
      logic [RW-1:0] dest;
      logic          rw;
      logic          mr;
      logic          mw;
      logic          exc;
      logic [4:0]    code;
   } exp_t;

   exp_t q[$];
   bit   squash_m = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] pack_exp(input exp_t e);
      return {18'd0, e.pc, e.result, e.sd, e.dest, e.rw, e.mr, e.mw, e.exc, e.code};
   endfunction

   function automatic logic [127:0] pack_dut();
      return {18'd0, bus.out_pc, bus.out_result, bus.out_store_data, bus.out_dest_reg,
              bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_exc, bus.out_exc_code};
   endfunction

   // Expected stored form of whatever EX is currently offering.
   function automatic exp_t classify();
      exp_t e;
      bit   ri, ov;
      ri = bus.in_op_invalid;
`ifdef EX_MEM_OVF_TRAP_EN
      ov = bus.in_overflow && bus.in_trap_ovf && !bus.in_op_invalid;
`else
      ov = 1'b0;
`endif
      e.pc     = bus.in_pc;
      e.result = bus.in_result;
      e.sd     = bus.in_store_data;
      e.dest   = bus.in_dest_reg;
      e.exc    = ri || ov;
      e.rw     = bus.in_reg_write && !e.exc;
      e.mr     = bus.in_mem_read  && !e.exc;
      e.mw     = bus.in_mem_write && !e.exc;
      e.code   = ri ? 5'd10 : (ov ? 5'd12 : 5'd0);
      return e;
   endfunction

   task automatic drive(input bit v, input logic [DW-1:0] res, input bit rw,
                        input bit inv, input bit ov, input bit tr);
      bus.in_valid      = v;
      bus.in_pc         = $urandom;
      bus.in_result     = res;
      bus.in_store_data = $urandom;
      bus.in_dest_reg   = RW'($urandom_range(0, 31));
      bus.in_reg_write  = rw;
      bus.in_mem_read   = 1'($urandom_range(0, 1));
      bus.in_mem_write  = 1'($urandom_range(0, 1));
      bus.in_op_invalid = inv;
      bus.in_overflow   = ov;
      bus.in_trap_ovf   = tr;
   endtask

   task automatic check_outputs();
      chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
      chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
      if (q.size() > 0)
         chk("head", pack_dut(), pack_exp(q[0]));
   endtask

   // One clock: model predicts handshakes from pre-edge inputs, then compares after the edge.
   task automatic step();
      bit   acc, pop;
      exp_t e;
      acc = bus.in_valid && (q.size() < 2);
      pop = (q.size() > 0) && bus.out_ready;
      e   = classify();
      @(posedge clk);
      if (flush) begin
         q.delete();
         squash_m = 1'b0;
      end else begin
         if (pop) q.delete(0);
         if (acc && !squash_m) begin
            q.push_back(e);
            if (e.exc) squash_m = 1'b1;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic do_flush();
      bus.in_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_fields", pack_dut(), 128'(0));
      rst_n = 1'b1;

      // Throughput: back-to-back entries 1..8, one per cycle, latency 1.
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         chk("tput_result", 128'(bus.out_result), 128'(i));
         chk("tput_valid", 128'(bus.out_valid), 128'(1));
      end
      bus.in_valid = 1'b0;
      step();

      // Stall then drain in order.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_head_A", 128'(bus.out_result), 128'(32'h11));
      step();
      chk("stall_hold_A", 128'(bus.out_result), 128'(32'h11));
      bus.out_ready = 1'b1;
      step();
      chk("drain_B", 128'(bus.out_result), 128'(32'h22));
      chk("drain_in_ready", 128'(bus.in_ready), 128'(1));
      step();
      chk("drain_empty", 128'(bus.out_valid), 128'(0));

      // Reset asserted mid-TWO takes effect before the next clock edge.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("pre_rst_full", 128'(bus.in_ready), 128'(0));
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 128'(bus.out_valid), 128'(0));
      chk("async_rst_ready", 128'(bus.in_ready), 128'(1));
      chk("async_rst_result", 128'(bus.out_result), 128'(0));
      q.delete();
      squash_m = 1'b0;
      #2;
      rst_n = 1'b1;

      // Reserved instruction: marked, side effects dropped, younger entries squashed.
      drive(1'b1, 32'hBAD, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("ri_exc", 128'(bus.out_exc), 128'(1));
      chk("ri_code", 128'(bus.out_exc_code), 128'(10));
      chk("ri_reg_write", 128'(bus.out_reg_write), 128'(0));
      chk("ri_result", 128'(bus.out_result), 128'(32'hBAD));
      drive(1'b1, 32'h501, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h502, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("ri_squash_ready", 128'(bus.in_ready), 128'(1));
      chk("ri_squash_head", 128'(bus.out_result), 128'(32'hBAD));
      do_flush();
      chk("ri_flush_valid", 128'(bus.out_valid), 128'(0));
      drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("post_flush_result", 128'(bus.out_result), 128'(32'h600));
      chk("post_flush_exc", 128'(bus.out_exc), 128'(0));
      chk("post_flush_rw", 128'(bus.out_reg_write), 128'(1));
      bus.out_ready = 1'b1;
      step();

      // Overflow classification.
      drive(1'b1, 32'h7FF, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      bus.in_valid = 1'b0;
`ifdef EX_MEM_OVF_TRAP_EN
      chk("ovf_exc", 128'(bus.out_exc), 128'(1));
      chk("ovf_code", 128'(bus.out_exc_code), 128'(12));
      chk("ovf_rw", 128'(bus.out_reg_write), 128'(0));
`else
      chk("ovf_exc", 128'(bus.out_exc), 128'(0));
      chk("ovf_code", 128'(bus.out_exc_code), 128'(0));
      chk("ovf_rw", 128'(bus.out_reg_write), 128'(1));
`endif
      do_flush();
      drive(1'b1, 32'h7FE, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("ovf_notrap_exc", 128'(bus.out_exc), 128'(0));
      chk("ovf_notrap_rw", 128'(bus.out_reg_write), 128'(1));
      do_flush();

      // Flush colliding with an offer while full.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("coll_valid", 128'(bus.out_valid), 128'(0));
      chk("coll_ready", 128'(bus.in_ready), 128'(1));
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("coll_no_emerge", 128'(bus.out_valid), 128'(0));
      end

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
         bus.out_ready = 1'($urandom_range(0, 2) != 0);
         flush = 1'($urandom_range(0, 19) == 0);
         step();
      end
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
